// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: register I/O port bundle for seg_scan_ctrl.
// The master drives address/strobe/data; the slave returns combinational read data.
interface seg_scan_ctrl_if;
  logic [3:0]  io_addr;
  logic        io_write_en;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;

  modport master (
    output io_addr,
    output io_write_en,
    output io_write_data,
    input  io_read_data
  );

  modport slave (
    input  io_addr,
    input  io_write_en,
    input  io_write_data,
    output io_read_data
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-segment scan controller.
// Registers: 0xC DATA (shadow digits), 0xD CTRL {P, MASK}, 0xE STAT (read-only).
// Each digit slot is a 16-cycle blank followed by a dwell of 2^(min(P,11)+4) cycles.
// A new frame's digits are committed from shadow on entry to digit 0's dwell.
// Optional macro HEX_DECODE_EN: full hex glyphs; otherwise only nibble bit 0 is shown.
module seg_scan_ctrl (
  input  logic           clk,
  input  logic           reset,
  seg_scan_ctrl_if.slave io,
  output logic [3:0]     AN,
  output logic [6:0]     LED
);

  localparam logic [1:0]  IDLE  = 2'd0;
  localparam logic [1:0]  BLANK = 2'd1;
  localparam logic [1:0]  DWELL = 2'd2;

  localparam logic [3:0]  ADDR_DATA = 4'hC;
  localparam logic [3:0]  ADDR_CTRL = 4'hD;
  localparam logic [3:0]  ADDR_STAT = 4'hE;

  localparam logic [15:0] BLANK_LAST = 16'd15;
  localparam logic [3:0]  P_MAX      = 4'd11;
  localparam logic [3:0]  P_RESET    = 4'd10;
  localparam logic [3:0]  AN_OFF     = 4'b1111;
  localparam logic [6:0]  LED_OFF    = 7'h7F;

  logic [15:0] shadow_q, shadow_d;
  logic [15:0] active_q, active_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  p_q, p_d;
  logic [3:0]  p_lat_q, p_lat_d;
  logic [1:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] blank_cnt_q, blank_cnt_d;
  logic [15:0] dwell_cnt_q, dwell_cnt_d;
  logic        frame_toggle_q, frame_toggle_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  led_q, led_d;

  logic [3:0]  p_eff;
  logic [15:0] dwell_last;
  logic [3:0]  nib;
  logic [6:0]  glyph;

  logic unused_wdata_hi;
  assign unused_wdata_hi = ^io.io_write_data[31:16];

  // Register file writes; only DATA and CTRL are writable.
  always_comb begin
    shadow_d = shadow_q;
    mask_d   = mask_q;
    p_d      = p_q;
    if (io.io_write_en) begin
      case (io.io_addr)
        ADDR_DATA: shadow_d = io.io_write_data[15:0];
        ADDR_CTRL: begin
          mask_d = io.io_write_data[3:0];
          p_d    = io.io_write_data[7:4];
        end
        default: ;
      endcase
    end
  end

  // Combinational readback of the register map.
  always_comb begin
    case (io.io_addr)
      ADDR_DATA: io.io_read_data = {16'd0, shadow_q};
      ADDR_CTRL: io.io_read_data = {24'd0, p_q, mask_q};
      ADDR_STAT: io.io_read_data = {27'd0, state_q, idx_q, frame_toggle_q};
      default:   io.io_read_data = '0;
    endcase
  end

  // Dwell terminal count from the P value latched at dwell entry, clamped to 11.
  always_comb begin
    p_eff      = (p_lat_q > P_MAX) ? P_MAX : p_lat_q;
    dwell_last = (16'd1 << (p_eff + 4'd4)) - 16'd1;
  end

  // Scan sequencing; an all-zero MASK forces IDLE from any state.
  // Counters default to 0 so that every state entry starts them from zero.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    blank_cnt_d    = '0;
    dwell_cnt_d    = '0;
    active_d       = active_q;
    frame_toggle_d = frame_toggle_q;
    p_lat_d        = p_lat_q;
    if (mask_q == '0) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
        end
        BLANK: begin
          if (blank_cnt_q == BLANK_LAST) begin
            state_d = DWELL;
            p_lat_d = p_q;
            if (idx_q == 2'd0) begin
              active_d       = shadow_q;
              frame_toggle_d = ~frame_toggle_q;
            end
          end else begin
            blank_cnt_d = blank_cnt_q + 16'd1;
          end
        end
        DWELL: begin
          if (dwell_cnt_q == dwell_last) begin
            state_d = BLANK;
            idx_d   = idx_q + 2'd1;
          end else begin
            dwell_cnt_d = dwell_cnt_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Segment glyph for the digit currently addressed by idx.
  always_comb begin
    nib = active_q[{idx_q, 2'b00} +: 4];
`ifdef HEX_DECODE_EN
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
`else
    glyph = nib[0] ? 7'h79 : 7'h40;
`endif
  end

`ifndef HEX_DECODE_EN
  logic unused_nib_hi;
  assign unused_nib_hi = ^nib[3:1];
`endif

  // Output drive: light one digit only while dwelling on an enabled slot.
  always_comb begin
    an_d  = AN_OFF;
    led_d = LED_OFF;
    if (state_q == DWELL && mask_q[idx_q]) begin
      an_d  = ~(4'b0001 << idx_q);
      led_d = glyph;
    end
  end

  // State registers; reset overrides any simultaneous I/O write.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q       <= '0;
      active_q       <= '0;
      mask_q         <= '1;
      p_q            <= P_RESET;
      p_lat_q        <= P_RESET;
      state_q        <= BLANK;
      idx_q          <= '0;
      blank_cnt_q    <= '0;
      dwell_cnt_q    <= '0;
      frame_toggle_q <= 1'b0;
      an_q           <= AN_OFF;
      led_q          <= LED_OFF;
    end else begin
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      mask_q         <= mask_d;
      p_q            <= p_d;
      p_lat_q        <= p_lat_d;
      state_q        <= state_d;
      idx_q          <= idx_d;
      blank_cnt_q    <= blank_cnt_d;
      dwell_cnt_q    <= dwell_cnt_d;
      frame_toggle_q <= frame_toggle_d;
      an_q           <= an_d;
      led_q          <= led_d;
    end
  end

  assign AN  = an_q;
  assign LED = led_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl.
// A deadline-based reference model tracks the display schedule in absolute cycles;
// hand sequences and a vector table cover the documented corner cases.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an;
  logic [6:0] led;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus),
    .AN    (an),
    .LED   (led)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  bit          check_en = 1'b0;

  // Reference model: display schedule expressed as segment deadlines.
  longint unsigned now = 0;
  longint unsigned m_seg_end;
  logic [15:0] m_shadow, m_active;
  logic [3:0]  m_mask, m_p;
  logic [1:0]  m_digit;
  bit          m_scan, m_lit, m_tog;
  logic [3:0]  m_an;
  logic [6:0]  m_led;

`ifdef HEX_DECODE_EN
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [6:0] EXP_D1 = 7'h24;
  localparam logic [6:0] EXP_D2 = 7'h30;
  localparam logic [6:0] EXP_D3 = 7'h19;
`else
  localparam logic [6:0] EXP_D1 = 7'h40;
  localparam logic [6:0] EXP_D2 = 7'h79;
  localparam logic [6:0] EXP_D3 = 7'h40;
`endif

  function automatic logic [6:0] tb_glyph(logic [3:0] n);
`ifdef HEX_DECODE_EN
    return hex_tab[n];
`else
    return n[0] ? 7'h79 : 7'h40;
`endif
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic logic [31:0] model_read(logic [3:0] a);
    logic [1:0] st;
    st = !m_scan ? 2'd0 : (m_lit ? 2'd2 : 2'd1);
    case (a)
      4'hC:    return {16'd0, m_shadow};
      4'hD:    return {24'd0, m_p, m_mask};
      4'hE:    return {27'd0, st, m_digit, m_tog};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_step(logic r, logic we, logic [3:0] a, logic [31:0] wd);
    logic [15:0] sh;
    int unsigned pe;
    now++;
    if (r) begin
      m_shadow = '0; m_active = '0; m_mask = 4'hF; m_p = 4'd10;
      m_scan = 1'b1; m_lit = 1'b0; m_digit = '0; m_tog = 1'b0;
      m_seg_end = now + 16;
      m_an = 4'hF; m_led = 7'h7F;
      return;
    end
    if (m_scan && m_lit && m_mask[m_digit]) begin
      sh    = m_active >> (4 * m_digit);
      m_an  = ~(4'b0001 << m_digit);
      m_led = tb_glyph(sh[3:0]);
    end else begin
      m_an  = 4'hF;
      m_led = 7'h7F;
    end
    if (m_mask == 4'd0) begin
      m_scan = 1'b0;
    end else if (!m_scan) begin
      m_scan = 1'b1; m_lit = 1'b0; m_digit = '0; m_seg_end = now + 16;
    end else if (now == m_seg_end) begin
      if (!m_lit) begin
        pe = (m_p > 11) ? 11 : int'(m_p);
        m_lit = 1'b1;
        m_seg_end = now + (64'd1 << (pe + 4));
        if (m_digit == 2'd0) begin
          m_active = m_shadow;
          m_tog    = ~m_tog;
        end
      end else begin
        m_lit = 1'b0; m_digit = m_digit + 2'd1; m_seg_end = now + 16;
      end
    end
    if (we) begin
      if (a == 4'hC) m_shadow = wd[15:0];
      if (a == 4'hD) begin m_mask = wd[3:0]; m_p = wd[7:4]; end
    end
  endfunction

  task automatic tick();
    logic r, we;
    logic [3:0] a;
    logic [31:0] wd;
    r = reset; we = bus.io_write_en; a = bus.io_addr; wd = bus.io_write_data;
    @(posedge clk);
    model_step(r, we, a, wd);
    #1;
    if (check_en) begin
      chk("an_vs_model",  {28'd0, an},  {28'd0, m_an});
      chk("led_vs_model", {25'd0, led}, {25'd0, m_led});
      chk("rd_vs_model",  bus.io_read_data, model_read(bus.io_addr));
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.io_addr = a; bus.io_write_data = d; bus.io_write_en = 1'b1;
    tick();
    bus.io_write_en = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] v, input int unsigned budget, input string name);
    int unsigned n;
    n = 0;
    while (an != v && n < budget) begin tick(); n++; end
    chk(name, {28'd0, an}, {28'd0, v});
  endtask

  task automatic run_len(input logic [3:0] v, input int unsigned budget, output int unsigned n);
    n = 0;
    while (an == v && n < budget) begin tick(); n++; end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    bit          check;
    logic [31:0] exp_rd;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    int unsigned n;
    logic [31:0] wd;
    vec_t vt [10];

    reset = 1'b1; bus.io_write_en = 1'b0; bus.io_addr = 4'hE; bus.io_write_data = '0;
    tick();
    check_en = 1'b1;
    tick();
    chk("reset_an",  {28'd0, an},  32'hF);
    chk("reset_led", {25'd0, led}, 32'h7F);
    chk("reset_stat", bus.io_read_data, 32'h08);
    bus.io_addr = 4'hD; #1;
    chk("reset_ctrl", bus.io_read_data, 32'hAF);
    bus.io_addr = 4'hC; #1;
    chk("reset_data", bus.io_read_data, 32'h0);
    bus.io_addr = 4'hE;
    reset = 1'b0;

    // First lit digit after reset, full P=10 dwell, blank gap, then digit 1.
    n = 0;
    while (an != 4'hE && n < 40) begin tick(); n++; end
    chk("first_lit_cycle", n, 17);
    chk("first_lit_led", {25'd0, led}, 32'h40);
    n = 0;
    while (an == 4'hE && n < 20000) begin
      if (n == 100) begin
        bus.io_write_en = 1'b1; bus.io_addr = 4'hC; bus.io_write_data = 32'h4321;
      end else if (n == 101) begin
        bus.io_write_en = 1'b1; bus.io_addr = 4'hD; bus.io_write_data = 32'h0F;
      end else begin
        bus.io_write_en = 1'b0; bus.io_addr = 4'hE;
      end
      tick();
      n++;
    end
    bus.io_write_en = 1'b0; bus.io_addr = 4'hE;
    chk("dwell_p10_len", n, 16384);
    run_len(4'hF, 100, n);
    chk("blank_gap_len", n, 16);
    chk("second_digit_an", {28'd0, an}, 32'hD);
    chk("old_active_kept", {25'd0, led}, 32'h40);

    // Next frame commits 0x4321.
    wait_an(4'hE, 300, "frame2_d0_an");
    chk("frame2_d0_led", {25'd0, led}, 32'h79);
    chk("frame_toggle_flip", {31'd0, bus.io_read_data[0]}, 32'd0);
    wait_an(4'hD, 100, "frame2_d1_an");
    chk("frame2_d1_led", {25'd0, led}, {25'd0, EXP_D1});
    wait_an(4'hB, 100, "frame2_d2_an");
    chk("frame2_d2_led", {25'd0, led}, {25'd0, EXP_D2});
    wait_an(4'h7, 100, "frame2_d3_an");
    chk("frame2_d3_led", {25'd0, led}, {25'd0, EXP_D3});

    // P=0, MASK=0101 slot pattern.
    wr(4'hD, 32'h05);
    bus.io_addr = 4'hE;
    wait_an(4'hE, 300, "mask5_d0_an");
    run_len(4'hE, 100, n);  chk("mask5_d0_len", n, 16);
    run_len(4'hF, 200, n);  chk("mask5_gap1_len", n, 48);
    chk("mask5_d2_an", {28'd0, an}, 32'hB);
    run_len(4'hB, 100, n);  chk("mask5_d2_len", n, 16);
    run_len(4'hF, 200, n);  chk("mask5_gap2_len", n, 48);
    chk("mask5_wrap_an", {28'd0, an}, 32'hE);

    // MASK cleared mid-dwell, then re-enabled.
    tick(); tick(); tick();
    wr(4'hD, 32'h00);
    bus.io_addr = 4'hE;
    tick();
    chk("idle_state", {30'd0, bus.io_read_data[4:3]}, 32'd0);
    chk("idle_an", {28'd0, an}, 32'hF);
    wr(4'hD, 32'h0F);
    bus.io_addr = 4'hE;
    n = 0;
    while (an != 4'hE && n < 100) begin tick(); n++; end
    chk("relit_latency", n, 18);

    // DATA write on the exact commit edge.
    wr(4'hC, 32'h1111);
    n = 0;
    while (!(m_scan && !m_lit && m_digit == 2'd0 && m_seg_end == now + 1) && n < 300) begin
      tick(); n++;
    end
    wr(4'hC, 32'h0000);
    chk("data_rb_commit_edge", bus.io_read_data, 32'h0);
    bus.io_addr = 4'hE;
    wait_an(4'hE, 50, "commit_d0_an");
    chk("commit_keeps_old", {25'd0, led}, 32'h79);
    run_len(4'hE, 100, n);
    wait_an(4'hE, 300, "next_frame_d0_an");
    chk("new_value_next_frame", {25'd0, led}, 32'h40);

    // DATA=0x1010 digit pattern, then P=15 clamps to a 32768-cycle dwell.
    wr(4'hC, 32'h1010);
    bus.io_addr = 4'hE;
    wait_an(4'hD, 100, "p1010_leave_d0");
    wait_an(4'hE, 300, "p1010_d0_an");  chk("p1010_d0_led", {25'd0, led}, 32'h40);
    wait_an(4'hD, 100, "p1010_d1_an");  chk("p1010_d1_led", {25'd0, led}, 32'h79);
    wait_an(4'hB, 100, "p1010_d2_an");  chk("p1010_d2_led", {25'd0, led}, 32'h40);
    wait_an(4'h7, 100, "p1010_d3_an");  chk("p1010_d3_led", {25'd0, led}, 32'h79);
    wr(4'hD, 32'hF1);
    bus.io_addr = 4'hE;
    wait_an(4'hE, 200, "p15_d0_an");
    run_len(4'hE, 40000, n);
    chk("dwell_p15_len", n, 32768);
    wr(4'hD, 32'h00);

    // Reset mid-dwell wins over a simultaneous CTRL write.
    wr(4'hD, 32'h0F);
    wait_an(4'hE, 100, "pre_reset_an");
    tick(); tick();
    reset = 1'b1; bus.io_write_en = 1'b1; bus.io_addr = 4'hD; bus.io_write_data = 32'h33;
    tick();
    reset = 1'b0; bus.io_write_en = 1'b0;
    chk("reset_vs_write_ctrl", bus.io_read_data, 32'hAF);
    chk("reset_vs_write_an", {28'd0, an}, 32'hF);
    bus.io_addr = 4'hE; #1;
    chk("reset_vs_write_stat", bus.io_read_data, 32'h08);

    // Register map vectors.
    vt[0] = '{1'b1, 4'hC, 32'hFFFF_ABCD, 1'b1, 32'h0000_ABCD};
    vt[1] = '{1'b0, 4'hC, 32'h0,         1'b1, 32'h0000_ABCD};
    vt[2] = '{1'b1, 4'hD, 32'hFFFF_FF3A, 1'b1, 32'h0000_003A};
    vt[3] = '{1'b0, 4'hD, 32'h0,         1'b1, 32'h0000_003A};
    vt[4] = '{1'b1, 4'h0, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vt[5] = '{1'b1, 4'hF, 32'h1234_5678, 1'b1, 32'h0};
    vt[6] = '{1'b0, 4'hC, 32'h0,         1'b1, 32'h0000_ABCD};
    vt[7] = '{1'b1, 4'hE, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[8] = '{1'b0, 4'hD, 32'h0,         1'b1, 32'h0000_003A};
    vt[9] = '{1'b1, 4'hD, 32'h0000_000F, 1'b1, 32'h0000_000F};
    for (int unsigned i = 0; i < 10; i++) begin
      bus.io_write_en = vt[i].we; bus.io_addr = vt[i].addr; bus.io_write_data = vt[i].wdata;
      tick();
      bus.io_write_en = 1'b0;
      if (vt[i].check) chk($sformatf("vec%0d_rd", i), bus.io_read_data, vt[i].exp_rd);
    end

    // Randomized traffic against the model.
    for (int unsigned c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      bus.io_addr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) bus.io_addr = 4'($urandom_range(12, 14));
      bus.io_write_en = ($urandom_range(0, 7) == 0);
      wd = $urandom;
      if (bus.io_addr == 4'hD) begin
        wd[7:4] = 4'($urandom_range(0, 1));
        if ($urandom_range(0, 5) == 0) wd[3:0] = 4'h0;
      end
      bus.io_write_data = wd;
      tick();
    end
    reset = 1'b0; bus.io_write_en = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
